smac_layer_seq: RTL

SMAC_LAYER_SEQ -- requirements
Module: smac_layer_seq

---
 rtl/smac_seq_pkg.sv | 43 ++++
 rtl/smac_layer_seq_tile_cnt.sv | 31 +++
 rtl/smac_layer_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/smac_seq_pkg.sv
// Package for the layer sequencer: state encoding, the captured layer
// configuration record, its field widths and a tile-count helper.
// The field widths track the default parameter values of smac_layer_seq.
package smac_seq_pkg;

    localparam int PA_DEF        = 8;
    localparam int PW_DEF        = 8;
    localparam int MNO_DEF       = 288;
    localparam int MNV_DEF       = 224 * 224;
    localparam int MAX_TILES_DEF = 1024;

    localparam int DONE_W  = $clog2(MNO_DEF);
    localparam int QUANT_W = $clog2(PA_DEF * PW_DEF);
    localparam int VOL_W   = $clog2(MNV_DEF);
    localparam int TILE_W  = $clog2(MAX_TILES_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_UPD_IN  = 3'd2,
        ST_UPD_OUT = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [DONE_W-1:0]  done_ops;
        logic [QUANT_W-1:0] quant;
        logic [2:0]         out;
        logic [2:0]         relu;
        logic [2:0]         fil_group;
        logic [VOL_W-1:0]   in_vol;
        logic               par_sel_pa;
        logic [1:0]         par_sel_pw;
        logic [TILE_W-1:0]  num_in_tiles;
        logic [TILE_W-1:0]  num_out_tiles;
    } seq_cfg_t;

    // Last valid tile index for a tile count; a count of 0 means one tile.
    function automatic logic [TILE_W-1:0] tile_max(input logic [TILE_W-1:0] count);
        return (count == '0) ? '0 : count - 1'b1;
    endfunction

endpackage

// File: rtl/smac_layer_seq_tile_cnt.sv
// seq_tile_cnt: wrapping tile index counter.
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous clear to 0 (has priority over inc)
//   inc          : advance; wraps to 0 when the count is at max_val
//   max_val      : last valid index
//   cnt          : current index
//   last         : cnt == max_val
module seq_tile_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == max_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/smac_layer_seq.sv
// smac_layer_seq: per-layer tile sequencer for the SMAC core.
// Accepts a layer configuration over a valid/ready handshake, holds it on
// the max_val_* / par_sel_* outputs, and walks input/output tiles in
// response to update_in / update_out pulses from the control unit. The
// core runs (core_stall_n=1) only in RUN; every tile update costs one stall
// cycle. layer_done pulses once after the last output tile.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   cfg_valid / cfg_ready    : configuration handshake (ready only in IDLE)
//   cfg_*                    : layer configuration fields
//   update_in / update_out   : tile advance pulses
//   core_stall_n             : run enable to the control unit
//   max_val_* / par_sel_*    : registered configuration copies
//   idx_in / idx_out         : current tile indices
//   busy, layer_done         : status
// Optional build macro SMAC_SEQ_PERF_CNT_EN adds run_cycles / stall_cycles
// (saturating, cleared on handshake).
module smac_layer_seq
    import smac_seq_pkg::*;
#(
    parameter int Pa        = 8,
    parameter int Pw        = 8,
    parameter int MNO       = 288,
    parameter int MNV       = 224 * 224,
    parameter int MAX_TILES = 1024,
    parameter int TW        = $clog2(MAX_TILES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(MNO)-1:0]    cfg_done_ops,
    input  logic [$clog2(Pa*Pw)-1:0]  cfg_quant,
    input  logic [2:0]                cfg_out,
    input  logic [2:0]                cfg_relu,
    input  logic [2:0]                cfg_fil_group,
    input  logic [$clog2(MNV)-1:0]    cfg_in_vol,
    input  logic                      cfg_par_sel_Pa,
    input  logic [1:0]                cfg_par_sel_Pw,
    input  logic [TW-1:0]             cfg_num_in_tiles,
    input  logic [TW-1:0]             cfg_num_out_tiles,
    input  logic                      update_in,
    input  logic                      update_out,
    output logic                      core_stall_n,
    output logic [$clog2(MNO)-1:0]    max_val_cnt_done,
    output logic [$clog2(Pa*Pw)-1:0]  max_val_cnt_quant,
    output logic [2:0]                max_val_cnt_out,
    output logic [2:0]                max_val_cnt_relu,
    output logic [2:0]                max_val_fil_group,
    output logic [$clog2(MNV)-1:0]    max_val_in_vol,
    output logic                      par_sel_Pa,
    output logic [1:0]                par_sel_Pw,
    output logic [TW-1:0]             idx_in,
    output logic [TW-1:0]             idx_out,
    output logic                      busy,
    output logic                      layer_done
`ifdef SMAC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]               run_cycles,
    output logic [31:0]               stall_cycles
`endif
);

    seq_state_t state, nxt;
    seq_cfg_t   cfg_q, cfg_in;
    logic       pending_in;
    logic       handshake;
    logic       in_last, out_last;

    assign handshake = cfg_valid && (state == ST_IDLE);

    assign cfg_in = '{
        done_ops:      cfg_done_ops,
        quant:         cfg_quant,
        out:           cfg_out,
        relu:          cfg_relu,
        fil_group:     cfg_fil_group,
        in_vol:        cfg_in_vol,
        par_sel_pa:    cfg_par_sel_Pa,
        par_sel_pw:    cfg_par_sel_Pw,
        num_in_tiles:  cfg_num_in_tiles,
        num_out_tiles: cfg_num_out_tiles
    };

    assign max_val_cnt_done  = cfg_q.done_ops;
    assign max_val_cnt_quant = cfg_q.quant;
    assign max_val_cnt_out   = cfg_q.out;
    assign max_val_cnt_relu  = cfg_q.relu;
    assign max_val_fil_group = cfg_q.fil_group;
    assign max_val_in_vol    = cfg_q.in_vol;
    assign par_sel_Pa        = cfg_q.par_sel_pa;
    assign par_sel_Pw        = cfg_q.par_sel_pw;

    // update_out wins over update_in; a deferred update_in is replayed
    // through pending_in on the next RUN cycle.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    if (cfg_valid) nxt = ST_RUN;
            ST_RUN: begin
                if (update_out)
                    nxt = out_last ? ST_DONE : ST_UPD_OUT;
                else if (update_in || pending_in)
                    nxt = ST_UPD_IN;
            end
            ST_UPD_IN,
            ST_UPD_OUT: nxt = ST_RUN;
            ST_DONE:    nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cfg_ready    <= 1'b1;
            busy         <= 1'b0;
            core_stall_n <= 1'b0;
            layer_done   <= 1'b0;
            pending_in   <= 1'b0;
            cfg_q        <= '0;
        end else begin
            state        <= nxt;
            cfg_ready    <= (nxt == ST_IDLE);
            busy         <= (nxt != ST_IDLE);
            core_stall_n <= (nxt == ST_RUN);
            layer_done   <= (nxt == ST_DONE);
            if (handshake)
                cfg_q <= cfg_in;
            if (handshake || nxt == ST_DONE)
                pending_in <= 1'b0;
            else if (state == ST_RUN && update_out && update_in)
                pending_in <= 1'b1;
            else if (state == ST_RUN && nxt == ST_UPD_IN)
                pending_in <= 1'b0;
        end
    end

    // Indices advance on the edge that leaves the update state.
    seq_tile_cnt #(.W(TW)) u_idx_in (
        .clk     (clk),
        .rst     (rst),
        .clr     (handshake),
        .inc     (state == ST_UPD_IN),
        .max_val (tile_max(cfg_q.num_in_tiles)),
        .cnt     (idx_in),
        .last    (in_last)
    );

    seq_tile_cnt #(.W(TW)) u_idx_out (
        .clk     (clk),
        .rst     (rst),
        .clr     (handshake),
        .inc     (state == ST_UPD_OUT),
        .max_val (tile_max(cfg_q.num_out_tiles)),
        .cnt     (idx_out),
        .last    (out_last)
    );

`ifdef SMAC_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles   <= '0;
            stall_cycles <= '0;
        end else if (handshake) begin
            run_cycles   <= '0;
            stall_cycles <= '0;
        end else begin
            if (state == ST_RUN && run_cycles != '1)
                run_cycles <= run_cycles + 32'd1;
            if ((state == ST_UPD_IN || state == ST_UPD_OUT) && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    // in_last only matters for wrap, which the counter handles internally.
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

`ifdef SMAC_SEQ_PERF_CNT_EN
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

endmodule
